// File: rtl/gayle_pkg.sv
// Shared constants for the Gayle sector-buffer FIFO: packet-command states and
// default geometry.
package gayle_pkg;

  typedef enum logic [1:0] {
    PKT_IDLE       = 2'd0,
    PKT_WAITCMD    = 2'd1,
    PKT_PROCESSCMD = 2'd2,
    PKT_RESERVED   = 2'd3
  } pkt_state_e;

  localparam int unsigned GAYLE_DW           = 16;
  localparam int unsigned GAYLE_SECTOR_WORDS = 256;
  localparam int unsigned GAYLE_SECTORS      = 16;
  localparam int unsigned GAYLE_PKT_WORDS    = 6;

endpackage

// File: rtl/gayle_fifo_ram.sv
// Simple dual-port synchronous RAM for the sector buffer; both ports gated by en,
// read data register cleared by reset.
module gayle_fifo_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Storage array kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/gayle_sector_fifo.sv
// Sector-buffer FIFO between the Gayle IDE registers and the ATA transfer engine.
// Define GAYLE_FIFO_ERR_EN to get sticky ovf/unf error flags; otherwise they read 0.
module gayle_sector_fifo
  import gayle_pkg::*;
#(
  parameter int unsigned DW           = GAYLE_DW,
  parameter int unsigned SECTOR_WORDS = GAYLE_SECTOR_WORDS,
  parameter int unsigned SECTORS      = GAYLE_SECTORS,
  parameter int unsigned PKT_WORDS    = GAYLE_PKT_WORDS,
  localparam int unsigned AW          = $clog2(SECTORS * SECTOR_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          flush,
  input  logic [DW-1:0] data_in,
  input  logic          wr,
  input  logic          rd,
  input  logic [1:0]    packet_state,
  output logic [DW-1:0] data_out,
  output logic          full,
  output logic          empty,
  output logic          last_in,
  output logic          last_out,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned DEPTH   = SECTORS * SECTOR_WORDS;
  localparam int unsigned SW      = $clog2(SECTOR_WORDS);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PKT_P   = (AW+1)'(PKT_WORDS);
  localparam logic [AW:0] ONE_P   = (AW+1)'(1);

  logic [AW:0] inptr_q, inptr_d;
  logic [AW:0] outptr_q, outptr_d;
  logic        empty_wr_q, empty_wr_d;
  logic [1:0]  pkt_q, pkt_d;

  logic [AW:0] used;
  logic        empty_rd;
  logic        at_depth;
  logic        clear;
  logic        wr_ok;
  logic        rd_ok;
  logic        ram_we;

  always_comb begin
    used     = inptr_q - outptr_q;
    empty_rd = (inptr_q == outptr_q);
    at_depth = (used == DEPTH_P);
    clear    = flush | (packet_state != pkt_q);
    wr_ok    = wr & ~at_depth;
    rd_ok    = rd & ~empty_rd;
    ram_we   = clk_en & wr_ok & ~clear & ~reset;
  end

  // Pointer next-state; a clear wins over any same-cycle wr/rd.
  always_comb begin
    inptr_d    = inptr_q;
    outptr_d   = outptr_q;
    empty_wr_d = empty_wr_q;
    pkt_d      = pkt_q;
    if (clk_en) begin
      pkt_d      = packet_state;
      empty_wr_d = empty_rd;
      if (clear) begin
        inptr_d    = '0;
        outptr_d   = '0;
        empty_wr_d = 1'b1;
      end else begin
        if (wr_ok) inptr_d = inptr_q + ONE_P;
        if (rd_ok) outptr_d = outptr_q + ONE_P;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inptr_q    <= '0;
      outptr_q   <= '0;
      empty_wr_q <= 1'b1;
      pkt_q      <= 2'(PKT_IDLE);
    end else begin
      inptr_q    <= inptr_d;
      outptr_q   <= outptr_d;
      empty_wr_q <= empty_wr_d;
      pkt_q      <= pkt_d;
    end
  end

  gayle_fifo_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .en    (clk_en),
    .we    (ram_we),
    .waddr (inptr_q[AW-1:0]),
    .wdata (data_in),
    .raddr (outptr_q[AW-1:0]),
    .rdata (data_out)
  );

  // empty_wr_q hides the RAM write-to-read latency for the first word.
  always_comb begin
    empty    = empty_rd | empty_wr_q;
    full     = (inptr_q[AW:SW] != outptr_q[AW:SW]) |
               ((packet_state == 2'(PKT_WAITCMD)) && (inptr_q == PKT_P));
    last_in  = (inptr_q[SW-1:0] == SW'(SECTOR_WORDS - 1));
    last_out = (outptr_q[SW-1:0] == SW'(SECTOR_WORDS - 1));
    level    = used;
  end

`ifdef GAYLE_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky drop flags; only reset or flush clears them, not a packet-state change.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clk_en) begin
      if (flush) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end else begin
        if (wr && at_depth) ovf_d = 1'b1;
        if (rd && empty_rd) unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_gayle_sector_fifo.sv
// Directed self-checking bench for gayle_sector_fifo; ovf/unf expectations follow
// GAYLE_FIFO_ERR_EN.
module tb_gayle_sector_fifo;
  import gayle_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4096;
  localparam int unsigned AW    = 12;
`ifdef GAYLE_FIFO_ERR_EN
  localparam logic [31:0] ERR = 32'd1;
`else
  localparam logic [31:0] ERR = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          reset, clk_en, flush, wr, rd;
  logic [1:0]    packet_state;
  logic [DW-1:0] data_in, data_out;
  logic          full, empty, last_in, last_out, ovf, unf;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gayle_sector_fifo #(
    .DW           (16),
    .SECTOR_WORDS (256),
    .SECTORS      (16),
    .PKT_WORDS    (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .flush        (flush),
    .data_in      (data_in),
    .wr           (wr),
    .rd           (rd),
    .packet_state (packet_state),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .last_in      (last_in),
    .last_out     (last_out),
    .level        (level),
    .ovf          (ovf),
    .unf          (unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One enabled edge followed by one disabled edge (inputs stay applied, must be ignored).
  task automatic tick();
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] wcnt, rcnt;
    reset = 1'b1; clk_en = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0;
    packet_state = 2'd0; data_in = '0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_full",     32'(full),     32'h0);
    check("rst_empty",    32'(empty),    32'h1);
    check("rst_last_in",  32'(last_in),  32'h0);
    check("rst_last_out", 32'(last_out), 32'h0);
    check("rst_level",    32'(level),    32'h0);
    check("rst_ovf",      32'(ovf),      32'h0);
    check("rst_unf",      32'(unf),      32'h0);
    tick();

    // 1: one full sector in, then out
    for (int i = 0; i < 256; i++) begin
      data_in = 16'(i);
      wr      = 1'b1;
      if (i == 254) check("t1_last_in_254", 32'(last_in), 32'h0);
      if (i == 255) check("t1_last_in_255", 32'(last_in), 32'h1);
      tick();
      if (i == 254) check("t1_full_254", 32'(full), 32'h0);
    end
    wr = 1'b0;
    check("t1_full",    32'(full),    32'h1);
    check("t1_level",   32'(level),   32'd256);
    check("t1_last_in", 32'(last_in), 32'h0);
    for (int k = 0; k < 256; k++) begin
      rd = 1'b1;
      if (k == 255) begin
        check("t1_last_out_255", 32'(last_out), 32'h1);
        check("t1_full_pre255",  32'(full),     32'h1);
      end
      tick();
      check("t1_rdata", 32'(data_out), 32'(k));
    end
    rd = 1'b0;
    check("t1_full_drop", 32'(full),     32'h0);
    check("t1_empty",     32'(empty),    32'h1);
    check("t1_level_0",   32'(level),    32'h0);
    check("t1_last_out",  32'(last_out), 32'h0);

    // 2: single write into empty FIFO
    data_in = 16'hBEEF; wr = 1'b1;
    tick();
    wr = 1'b0;
    check("t2_empty_hold", 32'(empty), 32'h1);
    check("t2_level",      32'(level), 32'h1);
    tick();
    check("t2_empty_clr", 32'(empty),    32'h0);
    check("t2_data",      32'(data_out), 32'hBEEF);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t2_empty_after_rd", 32'(empty), 32'h1);

    // 3: underflow drop, then fill to depth and overflow drop
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t3_unf_level", 32'(level), 32'h0);
    check("t3_unf",       32'(unf),   ERR);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_unf_flushed", 32'(unf), 32'h0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      data_in = 16'(i); wr = 1'b1;
      tick();
    end
    check("t3_level_full", 32'(level), 32'd4096);
    check("t3_full",       32'(full),  32'h1);
    check("t3_ovf_pre",    32'(ovf),   32'h0);
    data_in = 16'hDEAD;
    tick();
    wr = 1'b0;
    check("t3_level_hold", 32'(level),   32'd4096);
    check("t3_last_in",    32'(last_in), 32'h0);
    check("t3_ovf",        32'(ovf),     ERR);
    for (int k = 0; k < int'(DEPTH); k++) begin
      rd = 1'b1;
      tick();
      check("t3_rdata", 32'(data_out), 32'(k));
    end
    rd = 1'b0;
    check("t3_empty", 32'(empty), 32'h1);
    check("t3_level", 32'(level), 32'h0);

    // 4: ATAPI packet-command threshold
    packet_state = 2'(PKT_WAITCMD);
    tick();
    check("t4_ovf_kept", 32'(ovf),   ERR);
    check("t4_level0",   32'(level), 32'h0);
    for (int i = 0; i < 6; i++) begin
      data_in = 16'(16'h100 + i); wr = 1'b1;
      tick();
      if (i == 4) check("t4_full_5", 32'(full), 32'h0);
    end
    wr = 1'b0;
    check("t4_full_6",  32'(full),  32'h1);
    check("t4_level_6", 32'(level), 32'd6);
    packet_state = 2'(PKT_PROCESSCMD);
    tick();
    check("t4_clr_full",  32'(full),  32'h0);
    check("t4_clr_empty", 32'(empty), 32'h1);
    check("t4_clr_level", 32'(level), 32'h0);

    // 5: concurrent wr+rd across pointer wrap at level 100
    packet_state = 2'(PKT_IDLE);
    tick();
    check("t5_clr_level", 32'(level), 32'h0);
    wcnt = '0; rcnt = '0;
    for (int i = 0; i < 100; i++) begin
      data_in = wcnt; wr = 1'b1;
      tick();
      wcnt++;
    end
    check("t5_level_100", 32'(level), 32'd100);
    for (int i = 0; i < 8300; i++) begin
      data_in = wcnt; wr = 1'b1; rd = 1'b1;
      tick();
      wcnt++;
      check("t5_rdata", 32'(data_out), 32'(rcnt));
      rcnt++;
      if (i % 1000 == 999) check("t5_level", 32'(level), 32'd100);
    end
    wr = 1'b0; rd = 1'b0;
    check("t5_level_end", 32'(level), 32'd100);

    // 6: flush together with wr and rd at level 300
    for (int i = 0; i < 200; i++) begin
      data_in = wcnt; wr = 1'b1;
      tick();
      wcnt++;
    end
    wr = 1'b0;
    check("t6_level_300", 32'(level), 32'd300);
    check("t6_ovf_pre",   32'(ovf),   ERR);
    flush = 1'b1; wr = 1'b1; rd = 1'b1; data_in = 16'hCAFE;
    tick();
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    check("t6_level",  32'(level), 32'h0);
    check("t6_empty",  32'(empty), 32'h1);
    check("t6_full",   32'(full),  32'h0);
    check("t6_ovf",    32'(ovf),   32'h0);
    check("t6_unf",    32'(unf),   32'h0);
    tick();
    check("t6_level_hold", 32'(level), 32'h0);
    check("t6_empty_hold", 32'(empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
